reg_master_bridge: RTL and testbench

- Host-side register master that sits directly upstream of the register-group demux and drives its upstream register interface.
- Converts single-cycle host access pulses into a held reg_req transaction, then waits for reg_ack.
- Returns read data or 32'hdead_beef on timeout, drains lingering ack before the next access, and keeps saturating timeout/drop counters.

---
 rtl/reg_master_bridge_pkg.sv | 20 ++
 rtl/reg_master_bridge_if.sv | 32 +++
 rtl/reg_master_bridge_sat_counter.sv | 20 ++
 rtl/reg_master_bridge.sv | 156 +++++++++++++++
 tb/tb_reg_master_bridge.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_master_bridge_pkg.sv
// Shared types and constants for the host-side register master bridge.
// Data width comes from the platform-wide define when it is present.
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package reg_master_bridge_pkg;

    localparam int DATA_W = `CPCI_NF2_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Same value the group demux returns for an out-of-range address
    localparam logic [DATA_W-1:0] TIMEOUT_RD_DATA = DATA_W'(32'hdead_beef);

endpackage

// File: rtl/reg_master_bridge_if.sv
// Upstream register bus between the master bridge and the group demux.
// The master holds req/dir/addr/data; the slave answers with a level ack.
interface reg_master_bridge_if
    import reg_master_bridge_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic              reg_req;
    logic              reg_rd_wr_L;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wr_data;
    logic              reg_ack;
    logic [DATA_W-1:0] reg_rd_data;

    modport master (
        output reg_req,
        output reg_rd_wr_L,
        output reg_addr,
        output reg_wr_data,
        input  reg_ack,
        input  reg_rd_data
    );

    modport slave (
        input  reg_req,
        input  reg_rd_wr_L,
        input  reg_addr,
        input  reg_wr_data,
        output reg_ack,
        output reg_rd_data
    );
endinterface

// File: rtl/reg_master_bridge_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Used for the bridge's timeout and dropped-request statistics.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/reg_master_bridge.sv
// Host register master: turns a one-cycle host strobe into a held
// reg_req, waits for ack or timeout, then drains a lingering ack.
module reg_master_bridge
    import reg_master_bridge_pkg::*;
#(
    parameter int REG_ADDR_BITS  = 10,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     host_req,
    input  logic                     host_rd_wr_L,
    input  logic [REG_ADDR_BITS-1:0] host_addr,
    input  logic [DATA_W-1:0]        host_wr_data,
    output logic                     host_busy,
    output logic                     host_done,
    output logic [DATA_W-1:0]        host_rd_data,
    output logic                     host_timeout,

    reg_master_bridge_if.master      reg_bus,

    output logic [CNT_WIDTH-1:0]     timeout_cnt,
    output logic [CNT_WIDTH-1:0]     drop_cnt
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e                   state_q, state_n;
    logic [TW-1:0]            timer_q, timer_n;
    logic                     req_q, req_n;
    logic                     dir_q, dir_n;
    logic [REG_ADDR_BITS-1:0] addr_q, addr_n;
    logic [DATA_W-1:0]        wdata_q, wdata_n;
    logic                     busy_q, busy_n;
    logic                     done_q, done_n;
    logic [DATA_W-1:0]        rdata_q, rdata_n;
    logic                     to_q, to_n;
    logic                     to_inc;
    logic                     drop_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            req_q   <= 1'b0;
            dir_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
            req_q   <= req_n;
            dir_q   <= dir_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            rdata_q <= rdata_n;
            to_q    <= to_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        timer_n  = timer_q + 1'b1;
        req_n    = req_q;
        dir_n    = dir_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        done_n   = 1'b0;
        rdata_n  = rdata_q;
        to_n     = to_q;
        to_inc   = 1'b0;
        // Any strobe outside IDLE (including the done cycle) is lost
        drop_inc = host_req && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                timer_n = '0;
                if (host_req) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    dir_n   = host_rd_wr_L;
                    addr_n  = host_addr;
                    wdata_n = host_wr_data;
                end
            end
            REQ: begin
                // Ack beats a simultaneous timer expiry
                if (reg_bus.reg_ack) begin
                    state_n = DRAIN;
                    timer_n = '0;
                    req_n   = 1'b0;
                    done_n  = 1'b1;
                    to_n    = 1'b0;
                    if (dir_q) begin
                        rdata_n = reg_bus.reg_rd_data;
                    end
                end else if (timer_q == T_LAST) begin
                    state_n = DRAIN;
                    timer_n = '0;
                    req_n   = 1'b0;
                    done_n  = 1'b1;
                    to_n    = 1'b1;
                    rdata_n = TIMEOUT_RD_DATA;
                    to_inc  = 1'b1;
                end
            end
            DRAIN: begin
                if (!reg_bus.reg_ack || timer_q == T_LAST) begin
                    state_n = IDLE;
                    timer_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
                req_n   = 1'b0;
            end
        endcase
    end

    assign busy_n = (state_n != IDLE);

    assign host_busy    = busy_q;
    assign host_done    = done_q;
    assign host_rd_data = rdata_q;
    assign host_timeout = to_q;

    assign reg_bus.reg_req     = req_q;
    assign reg_bus.reg_rd_wr_L = dir_q;
    assign reg_bus.reg_addr    = addr_q;
    assign reg_bus.reg_wr_data = wdata_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_timeout_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (to_inc),
        .count   (timeout_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (drop_inc),
        .count   (drop_cnt)
    );

endmodule

// File: tb/tb_reg_master_bridge.sv
// Bench for reg_master_bridge: scripted slave on the register bus,
// completions checked against a queue of expected host results.
module tb_reg_master_bridge;
    import reg_master_bridge_pkg::*;

    localparam int AW = 10;
    localparam int TO = 64;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              host_req = 1'b0;
    logic              host_rd_wr_L = 1'b0;
    logic [AW-1:0]     host_addr = '0;
    logic [DATA_W-1:0] host_wr_data = '0;
    logic              host_busy;
    logic              host_done;
    logic [DATA_W-1:0] host_rd_data;
    logic              host_timeout;
    logic [CW-1:0]     timeout_cnt;
    logic [CW-1:0]     drop_cnt;

    reg_master_bridge_if #(.ADDR_W(AW)) bus ();

    reg_master_bridge #(
        .REG_ADDR_BITS  (AW),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .host_req     (host_req),
        .host_rd_wr_L (host_rd_wr_L),
        .host_addr    (host_addr),
        .host_wr_data (host_wr_data),
        .host_busy    (host_busy),
        .host_done    (host_done),
        .host_rd_data (host_rd_data),
        .host_timeout (host_timeout),
        .reg_bus      (bus),
        .timeout_cnt  (timeout_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              to;
    } exp_t;

    exp_t              sb[$];
    int                n_cmp = 0;
    int                n_err = 0;
    logic [DATA_W-1:0] last_rd = '0;

    // Every completion must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset_n && host_done) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_done: rd_data=%h timeout=%b, none expected",
                         host_rd_data, host_timeout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (host_rd_data !== e.data || host_timeout !== e.to) begin
                    n_err++;
                    $display("FAIL sb_done: rd_data=%h timeout=%b, expected %h/%b",
                             host_rd_data, host_timeout, e.data, e.to);
                end
            end
        end
    end

    // lat<0: never ack; ack driven at negedge lat+1 after reg_req is seen
    task automatic drive_access(
        input  logic              rd,
        input  logic [AW-1:0]     a,
        input  logic [DATA_W-1:0] d,
        input  int                lat,
        input  int                hold,
        input  int                poke,
        output int                done_k,
        output int                end_k,
        output int                req_k,
        output int                diff_k,
        output int                rises
    );
        exp_t e;
        logic prev;
        @(negedge clk);
        host_req         = 1'b1;
        host_rd_wr_L     = rd;
        host_addr        = a;
        host_wr_data     = d;
        bus.reg_rd_data  = rd ? d : ~d;
        e.to   = (lat < 0) || (lat + 1 > TO);
        e.data = e.to ? 32'hdead_beef : (rd ? d : last_rd);
        last_rd = e.data;
        sb.push_back(e);
        done_k = -1;
        end_k  = -1;
        req_k  = 0;
        diff_k = 0;
        rises  = 0;
        prev   = 1'b0;
        for (int k = 1; k < 400; k++) begin
            @(negedge clk);
            host_req = (k == poke);
            if (bus.reg_req) begin
                req_k++;
                if (bus.reg_addr !== a || bus.reg_rd_wr_L !== rd ||
                    bus.reg_wr_data !== d) diff_k++;
            end
            if (bus.reg_req && !prev) rises++;
            prev = bus.reg_req;
            if (lat >= 0 && k == lat + 1) bus.reg_ack = 1'b1;
            if (host_done && done_k < 0) done_k = k;
            if (done_k >= 0 && k >= done_k + hold) bus.reg_ack = 1'b0;
            if (done_k >= 0 && !host_busy) begin
                end_k = k;
                break;
            end
        end
        host_req    = 1'b0;
        bus.reg_ack = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if ({host_busy, host_done, host_timeout, bus.reg_req, bus.reg_rd_wr_L} !== 5'b0 ||
            host_rd_data !== '0 || bus.reg_addr !== '0 || bus.reg_wr_data !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b done=%b req=%b rd=%h addr=%h, expected all 0",
                     host_busy, host_done, bus.reg_req, host_rd_data, bus.reg_addr);
        end
        n_cmp++;
        if (timeout_cnt !== '0 || drop_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_counters: timeout=%0d drop=%0d, expected 0/0",
                     timeout_cnt, drop_cnt);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read;
        int dk, ek, rk, fk, ri;
        drive_access(1'b1, 10'h042, 32'h1234_5678, 1, 0, -1, dk, ek, rk, fk, ri);
        n_cmp++;
        if (dk !== 3) begin
            n_err++;
            $display("FAIL read_done_cycle: got %0d, expected 3", dk);
        end
        n_cmp++;
        if (rk !== 2 || ri !== 1) begin
            n_err++;
            $display("FAIL read_req_width: high %0d cycles %0d rises, expected 2/1", rk, ri);
        end
        n_cmp++;
        if (ek !== 4) begin
            n_err++;
            $display("FAIL read_idle_cycle: got %0d, expected 4", ek);
        end
    endtask

    task automatic test_write;
        int dk, ek, rk, fk, ri;
        drive_access(1'b0, 10'h155, 32'hcafe_f00d, 2, 0, -1, dk, ek, rk, fk, ri);
        n_cmp++;
        if (fk !== 0 || rk !== 3) begin
            n_err++;
            $display("FAIL write_hold: %0d bad of %0d req cycles, expected 0 of 3", fk, rk);
        end
        n_cmp++;
        if (dk !== 4) begin
            n_err++;
            $display("FAIL write_done_cycle: got %0d, expected 4", dk);
        end
    endtask

    task automatic test_timeout;
        int dk, ek, rk, fk, ri;
        drive_access(1'b0, 10'h3a0, 32'h0000_0011, -1, 0, -1, dk, ek, rk, fk, ri);
        n_cmp++;
        if (dk !== TO + 1) begin
            n_err++;
            $display("FAIL timeout_done_cycle: got %0d, expected %0d", dk, TO + 1);
        end
        n_cmp++;
        if (timeout_cnt !== CW'(1)) begin
            n_err++;
            $display("FAIL timeout_cnt: got %0d, expected 1", timeout_cnt);
        end
        n_cmp++;
        if (ek !== TO + 2 || fk !== 0) begin
            n_err++;
            $display("FAIL timeout_idle: end %0d bad %0d, expected %0d/0", ek, fk, TO + 2);
        end
    endtask

    task automatic test_ack_at_expiry;
        int dk, ek, rk, fk, ri;
        drive_access(1'b1, 10'h001, 32'h7e57_0001, TO - 1, 0, -1, dk, ek, rk, fk, ri);
        n_cmp++;
        if (dk !== TO + 1) begin
            n_err++;
            $display("FAIL expiry_done_cycle: got %0d, expected %0d", dk, TO + 1);
        end
        n_cmp++;
        if (timeout_cnt !== CW'(1)) begin
            n_err++;
            $display("FAIL expiry_timeout_cnt: got %0d, expected 1", timeout_cnt);
        end
    endtask

    task automatic test_drop;
        int dk, ek, rk, fk, ri;
        drive_access(1'b1, 10'h2aa, 32'h00c0_ffee, 1, 3, 4, dk, ek, rk, fk, ri);
        n_cmp++;
        if (drop_cnt !== CW'(1)) begin
            n_err++;
            $display("FAIL drop_cnt: got %0d, expected 1", drop_cnt);
        end
        n_cmp++;
        if (ek !== 7 || ri !== 1) begin
            n_err++;
            $display("FAIL drop_drain: idle at %0d rises %0d, expected 7/1", ek, ri);
        end
        drive_access(1'b1, 10'h2ab, 32'h5151_a0a0, 1, 0, -1, dk, ek, rk, fk, ri);
        n_cmp++;
        if (dk !== 3 || drop_cnt !== CW'(1)) begin
            n_err++;
            $display("FAIL drop_next: done %0d drop %0d, expected 3/1", dk, drop_cnt);
        end
    endtask

    task automatic test_reset_mid_req;
        int dk, ek, rk, fk, ri;
        @(negedge clk);
        host_req     = 1'b1;
        host_rd_wr_L = 1'b1;
        host_addr    = 10'h3ff;
        host_wr_data = 32'h1111_2222;
        @(negedge clk);
        host_req = 1'b0;
        n_cmp++;
        if (bus.reg_req !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre_req: reg_req=%b, expected 1", bus.reg_req);
        end
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.reg_req, host_busy, host_done, host_timeout} !== 4'b0 ||
            bus.reg_addr !== '0 || host_rd_data !== '0) begin
            n_err++;
            $display("FAIL rst_async_outputs: req=%b busy=%b addr=%h rd=%h, expected 0",
                     bus.reg_req, host_busy, bus.reg_addr, host_rd_data);
        end
        n_cmp++;
        if (timeout_cnt !== '0 || drop_cnt !== '0) begin
            n_err++;
            $display("FAIL rst_async_counters: timeout=%0d drop=%0d, expected 0/0",
                     timeout_cnt, drop_cnt);
        end
        last_rd = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        drive_access(1'b1, 10'h010, 32'h0bad_cafe, 1, 0, -1, dk, ek, rk, fk, ri);
        n_cmp++;
        if (dk !== 3 || ek !== 4) begin
            n_err++;
            $display("FAIL rst_fresh_access: done %0d idle %0d, expected 3/4", dk, ek);
        end
    endtask

    initial begin
        bus.reg_ack     = 1'b0;
        bus.reg_rd_data = '0;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_ack_at_expiry();
        test_drop();
        test_reset_mid_req();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
